// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle enable/flush controls for the 5-stage core,
// resolving halt, data-memory wait, taken branch and load-use hazards, plus stall statistics.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_if_id_rs,
  input  logic [4:0]       i_if_id_rt,
  input  logic             i_if_id_usesRt,
  input  logic [4:0]       i_id_ex_rt,
  input  logic             i_id_ex_memRead,
  input  logic             i_ex_mem_memRead,
  input  logic             i_ex_mem_memWrite,
  input  logic             i_mem_ready,
  input  logic             i_branch_taken,
  input  logic             i_halt,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_id_ex_write,
  output logic             o_ex_mem_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_mem_wb_flush,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic             o_mem_error,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] next_wait;
  logic              set_error;
  logic              mem_acc;
  logic              load_use;

  assign mem_acc  = i_ex_mem_memRead | i_ex_mem_memWrite;
  assign load_use = i_id_ex_memRead && (i_id_ex_rt != 5'd0) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_if_id_usesRt && (i_id_ex_rt == i_if_id_rt)));

  // Control outputs react in the same cycle as the hazard; the latches act on the next edge.
  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_id_ex_write  = 1'b1;
    o_ex_mem_write = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_mem_wb_flush = 1'b0;
    next_state     = state;
    next_wait      = wait_cnt;
    set_error      = 1'b0;

    if (!rst) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_mem_wb_flush = 1'b1;
      next_state     = RUN;
    end else if (state == HALTED) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_id_ex_flush = 1'b1;
    end else if (state == MEM_WAIT && !i_mem_ready) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_write  = 1'b0;
      o_ex_mem_write = 1'b0;
      o_mem_wb_flush = 1'b1;
      if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
        set_error  = 1'b1;
        next_state = HALTED;
      end else begin
        next_wait = wait_cnt + 1'b1;
      end
    end else if (i_halt) begin
      next_state = HALTED;
    end else if (mem_acc && !i_mem_ready) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_write  = 1'b0;
      o_ex_mem_write = 1'b0;
      o_mem_wb_flush = 1'b1;
      next_state     = MEM_WAIT;
      next_wait      = WAIT_W'(1);
    end else if (i_branch_taken) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      next_state    = RUN;
    end else if (load_use && state != LU_STALL) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_id_ex_flush = 1'b1;
      next_state    = LU_STALL;
    end else begin
      next_state = RUN;
    end
  end

  // Counters saturate rather than wrap; halted cycles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RUN;
      wait_cnt       <= '0;
      o_mem_error    <= 1'b0;
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
      if (set_error)
        o_mem_error <= 1'b1;
      if (!o_pc_write && state != HALTED && o_stall_cycles != '1)
        o_stall_cycles <= o_stall_cycles + 1'b1;
      if (o_if_id_flush && o_flush_count != '1)
        o_flush_count <= o_flush_count + 1'b1;
    end
  end

  assign o_state  = state;
  assign o_halted = (state == HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl, with a second instance using
// 4-bit counters to exercise saturation.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 15;

  // Control pattern order: {pc, if_id, id_ex, ex_mem writes, if_id, id_ex, mem_wb flushes}
  localparam logic [6:0] P_NORMAL = 7'b1111_000;
  localparam logic [6:0] P_FREEZE = 7'b0000_001;
  localparam logic [6:0] P_BRANCH = 7'b1111_110;
  localparam logic [6:0] P_BUBBLE = 7'b0011_010;
  localparam logic [6:0] P_RESET  = 7'b0011_111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        uses_rt, id_ex_mem_read, ex_mem_mem_read, ex_mem_mem_write;
  logic        mem_ready, branch_taken, halt;

  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]  state;
  logic        halted, mem_error;
  logic [15:0] stall_cycles, flush_count;

  logic        s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write;
  logic        s_if_id_flush, s_id_ex_flush, s_mem_wb_flush;
  logic [1:0]  s_state;
  logic        s_halted, s_mem_error;
  logic [3:0]  s_stall_cycles, s_flush_count;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt), .i_if_id_usesRt(uses_rt),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_memRead(id_ex_mem_read),
    .i_ex_mem_memRead(ex_mem_mem_read), .i_ex_mem_memWrite(ex_mem_mem_write),
    .i_mem_ready(mem_ready), .i_branch_taken(branch_taken), .i_halt(halt),
    .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_id_ex_write(id_ex_write),
    .o_ex_mem_write(ex_mem_write), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_mem_wb_flush(mem_wb_flush), .o_state(state), .o_halted(halted),
    .o_mem_error(mem_error), .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt), .i_if_id_usesRt(uses_rt),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_memRead(id_ex_mem_read),
    .i_ex_mem_memRead(ex_mem_mem_read), .i_ex_mem_memWrite(ex_mem_mem_write),
    .i_mem_ready(mem_ready), .i_branch_taken(branch_taken), .i_halt(halt),
    .o_pc_write(s_pc_write), .o_if_id_write(s_if_id_write), .o_id_ex_write(s_id_ex_write),
    .o_ex_mem_write(s_ex_mem_write), .o_if_id_flush(s_if_id_flush), .o_id_ex_flush(s_id_ex_flush),
    .o_mem_wb_flush(s_mem_wb_flush), .o_state(s_state), .o_halted(s_halted),
    .o_mem_error(s_mem_error), .o_stall_cycles(s_stall_cycles), .o_flush_count(s_flush_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0=run, 1=one-cycle load-use stall, 2=waiting on memory, 3=halted
  int         m_phase = 0;
  int         m_waited = 0;
  bit         m_err = 1'b0;
  int         m_stalls = 0;
  int         m_flushes = 0;
  logic [6:0] e_pat;
  int         e_phase, e_waited;
  bit         e_err;

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict this cycle's controls and the following phase from the hazard rules.
  task automatic modelEval();
    bit access_pending = (ex_mem_mem_read || ex_mem_mem_write) && !mem_ready;
    bit load_hazard = id_ex_mem_read && id_ex_rt != 0 &&
                      (id_ex_rt == if_id_rs || (uses_rt && id_ex_rt == if_id_rt));
    e_pat = P_NORMAL;
    e_phase = 0;
    e_waited = m_waited;
    e_err = m_err;
    if (!rst) begin
      e_pat = P_RESET;
    end else if (m_phase == 3) begin
      e_pat = P_BUBBLE;
      e_phase = 3;
    end else if (m_phase == 2 && !mem_ready) begin
      e_pat = P_FREEZE;
      if (m_waited >= TIMEOUT) begin
        e_phase = 3;
        e_err = 1'b1;
      end else begin
        e_phase = 2;
        e_waited = m_waited + 1;
      end
    end else if (halt) begin
      e_phase = 3;
    end else if (access_pending) begin
      e_pat = P_FREEZE;
      e_phase = 2;
      e_waited = 1;
    end else if (branch_taken) begin
      e_pat = P_BRANCH;
    end else if (load_hazard && m_phase != 1) begin
      e_pat = P_BUBBLE;
      e_phase = 1;
    end
  endtask

  task automatic modelCommit();
    if (!rst) begin
      m_phase = 0; m_waited = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e_pat[6] && m_phase != 3) m_stalls++;
      if (e_pat[2]) m_flushes++;
      m_phase = e_phase;
      m_waited = e_waited;
      m_err = e_err;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    modelEval();
    checkOutput("controls", {pc_write, if_id_write, id_ex_write, ex_mem_write,
                             if_id_flush, id_ex_flush, mem_wb_flush}, e_pat);
    checkOutput("state", state, m_phase);
    checkOutput("halted", halted, (m_phase == 3));
    checkOutput("mem_error", mem_error, m_err);
    checkOutput("stall_cycles", stall_cycles, sat(m_stalls, 16));
    checkOutput("flush_count", flush_count, sat(m_flushes, 16));
    checkOutput("sat_state", s_state, m_phase);
    checkOutput("sat_stall_cycles", s_stall_cycles, sat(m_stalls, 4));
    checkOutput("sat_flush_count", s_flush_count, sat(m_flushes, 4));
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  task automatic setIdle();
    rst = 1'b1;
    if_id_rs = 5'd0; if_id_rt = 5'd0; id_ex_rt = 5'd0; uses_rt = 1'b0;
    id_ex_mem_read = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
    mem_ready = 1'b1; branch_taken = 1'b0; halt = 1'b0;
  endtask

  initial begin
    setIdle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus();
    setIdle();
    applyStimulus();

    // Load-use on rs costs one bubble, then a register-zero load must not stall.
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("lu_stall_total", stall_cycles, 1);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    applyStimulus();
    setIdle();

    // Branch outranks a simultaneous load-use match.
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; if_id_rt = 5'd7; uses_rt = 1'b1; branch_taken = 1'b1;
    applyStimulus();
    setIdle();
    applyStimulus();

    // Memory ready arrives after three low cycles.
    ex_mem_mem_read = 1'b1; mem_ready = 1'b0;
    repeat (3) applyStimulus();
    mem_ready = 1'b1;
    applyStimulus();
    setIdle();
    applyStimulus();

    // Ready held low until the timeout halts the core with a sticky error.
    ex_mem_mem_write = 1'b1; mem_ready = 1'b0;
    repeat (16) applyStimulus();
    checkOutput("timeout_state", state, 3);
    checkOutput("timeout_error", mem_error, 1);
    repeat (2) applyStimulus();
    rst = 1'b0;
    applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("post_reset_state", state, 0);

    // Halt wins over a simultaneous taken branch; the pipe then drains.
    halt = 1'b1; branch_taken = 1'b1;
    applyStimulus();
    setIdle();
    repeat (3) applyStimulus();
    rst = 1'b0;
    applyStimulus();
    setIdle();

    for (int i = 0; i < 3000; i++) begin
      rst              = !(m_phase == 3 && $urandom_range(7) == 0) && ($urandom_range(299) != 0);
      if_id_rs         = 5'($urandom_range(3));
      if_id_rt         = 5'($urandom_range(3));
      id_ex_rt         = 5'($urandom_range(3));
      uses_rt          = 1'($urandom_range(1));
      id_ex_mem_read   = ($urandom_range(2) == 0);
      ex_mem_mem_read  = ($urandom_range(4) == 0);
      ex_mem_mem_write = ($urandom_range(6) == 0);
      mem_ready        = ($urandom_range(3) != 0);
      branch_taken     = ($urandom_range(5) == 0);
      halt             = ($urandom_range(149) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
